decode_38_hold: RTL and testbench
=================================

DECODE_38_HOLD -- requirements
Module: decode_38_hold

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 4, setting the number of cycles each decoded one-hot word is driven; legal range 1..255, and a value of 0 SHALL behave as 1.
REQ-002 The block SHALL have parameter CNT_W, default 8, setting the hold counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the clk rising edge.
REQ-005 The block SHALL have port din, input, 3 bits: binary code to decode, 0..7.
REQ-006 The block SHALL have port din_valid, input, 1 bit: din carries a code to accept.
REQ-007 The block SHALL have port din_ready, output, 1 bit: the block can accept a code this cycle.
REQ-008 The block SHALL have port en, input, 1 bit: output enable; 0 forces dout to zero.
REQ-009 The block SHALL have port dout, output, 8 bits: one-hot decoded word, bit[din] set.
REQ-010 The block SHALL have port busy, output, 1 bit: a decoded word is being held.
REQ-011 The block SHALL have port done, output, 1 bit: single-cycle pulse at the end of each hold.
REQ-012 The block SHALL have port last_code, output, 3 bits: most recently accepted code.

Function
REQ-013 The block SHALL implement a two-state machine: IDLE and HOLD.
REQ-014 In IDLE, the block SHALL drive din_ready=1, busy=0 and the internal one-hot register = 8'h00.
REQ-015 A transfer SHALL occur on a clk edge where din_valid=1 and din_ready=1; there is no other accept condition.
REQ-016 On a transfer, the next cycle SHALL have: state=HOLD, internal one-hot register = 8'h01 << din, last_code=din, busy=1, hold counter=HOLD_CYCLES-1.
REQ-017 The latency from the accept edge to dout valid SHALL be exactly one clock.
REQ-018 In HOLD, the block SHALL drive din_ready=0, and din_valid SHALL be ignored; no queuing, so a code offered during HOLD is not captured.
REQ-019 In HOLD with counter != 0, the counter SHALL decrement by 1 per cycle and the one-hot register SHALL hold its value.
REQ-020 In HOLD with counter == 0, the next edge SHALL return the block to IDLE, clear the one-hot register to 8'h00, deassert busy, and assert done for exactly that one following cycle.
REQ-021 The one-hot word SHALL therefore be present for exactly HOLD_CYCLES cycles.
REQ-022 Because din_ready reasserts only in IDLE, back-to-back codes SHALL be separated by at least one cycle of dout=8'h00.
REQ-023 dout SHALL equal the one-hot register when en=1 and 8'h00 when en=0, gated combinationally.
REQ-024 en SHALL NOT affect the state, the counter, busy, done or din_ready; a hold continues to time out while en=0.
REQ-025 dout SHALL never have more than one bit set.
REQ-026 A code of 0 SHALL produce dout=8'h01 (it is not "no output").
REQ-027 last_code SHALL hold its value until the next transfer.

Reset
REQ-028 With rst_n=0 at a clk edge, the next cycle SHALL have: state=IDLE, one-hot register=8'h00, dout=8'h00, counter=0, busy=0, done=0, last_code=3'd0, din_ready=1.
REQ-029 Reset SHALL override any in-progress HOLD without generating done.
REQ-030 A transfer presented on the same edge as rst_n=0 SHALL be discarded.
REQ-031 rst_n SHALL have no asynchronous effect.

Verification
REQ-032 HOLD_CYCLES=4, en=1, din=5 with din_valid pulsed for one cycle -> dout=8'h20 on cycles 1-4 after accept; cycle 5: dout=8'h00, done=1, din_ready=1; last_code=5.
REQ-033 Sweep din=0..7, each accepted as soon as din_ready=1 -> dout sequence 01,02,04,08,10,20,40,80, each 4 cycles wide, with one zero cycle between words; done pulses count = 8.
REQ-034 din_valid held at 1 with din changing to 3 during a hold of code 6 -> dout stays 8'h40 for the full hold; 3 is accepted only on the first IDLE cycle after the hold.
REQ-035 Accept code 2, drive en=0 for cycles 2-3 of the hold -> dout=8'h00 on those cycles and 8'h04 otherwise; done still occurs on cycle 5.
REQ-036 Accept code 7, assert rst_n=0 on hold cycle 2 -> next cycle dout=8'h00, busy=0, last_code=0, and no done pulse.
REQ-037 HOLD_CYCLES=1 and HOLD_CYCLES=0 -> dout is one-hot for exactly 1 cycle, followed by a cycle with done=1.

Source files
------------

// File: rtl/decode_38_hold.sv
// 3-to-8 one-hot decoder that accepts a code over a valid/ready handshake and
// holds the decoded word for HOLD_CYCLES clocks before returning to idle.
//
//   state | meaning
//   IDLE  | ready for a code, one-hot register cleared
//   HOLD  | driving the decoded word, counter running down to zero
module decode_38_hold #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             en,
    output logic [7:0]       dout,
    output logic             busy,
    output logic             done,
    output logic [2:0]       last_code
);

    // A zero hold length is treated as a single-cycle hold.
    localparam int               HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_EFF - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       onehot, onehot_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       code_q, code_nxt;
    logic             done_q, done_nxt;
    logic             accept;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            onehot <= 8'h00;
            cnt    <= '0;
            code_q <= 3'd0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            onehot <= onehot_nxt;
            cnt    <= cnt_nxt;
            code_q <= code_nxt;
            done_q <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        onehot_nxt = onehot;
        cnt_nxt    = cnt;
        code_nxt   = code_q;
        done_nxt   = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                onehot_nxt = 8'h00;
                accept     = din_valid;
                if (accept) begin
                    state_nxt  = HOLD;
                    onehot_nxt = 8'h01 << din;
                    cnt_nxt    = CNT_LOAD;
                    code_nxt   = din;
                end
            end
            HOLD: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    state_nxt  = IDLE;
                    onehot_nxt = 8'h00;
                    done_nxt   = 1'b1;
                end
            end
            default: begin
                state_nxt  = IDLE;
                onehot_nxt = 8'h00;
            end
        endcase
    end

    assign din_ready = (state == IDLE);
    assign busy      = (state == HOLD);
    assign done      = done_q;
    assign last_code = code_q;
    // Enable gates only the visible word; timing continues underneath.
    assign dout      = en ? onehot : 8'h00;

endmodule

// File: tb/tb_decode_38_hold.sv
// Scoreboard bench for decode_38_hold: stimulus queues expected words, a
// negedge monitor retires one entry per done pulse; directed spot checks too.
module tb_decode_38_hold;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] din;
    logic       din_valid;
    logic       en;
    logic       dv_s;

    logic       din_ready, busy, done;
    logic [7:0] dout;
    logic [2:0] last_code;

    logic       rdy1, busy1, done1, rdy0, busy0, done0;
    logic [7:0] dout1, dout0;
    logic [2:0] lc1, lc0;

    always #5 clk = ~clk;

    decode_38_hold #(.HOLD_CYCLES(4), .CNT_W(8)) u_h4 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .en(en), .dout(dout), .busy(busy),
        .done(done), .last_code(last_code));

    decode_38_hold #(.HOLD_CYCLES(1), .CNT_W(8)) u_h1 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(dv_s),
        .din_ready(rdy1), .en(en), .dout(dout1), .busy(busy1),
        .done(done1), .last_code(lc1));

    decode_38_hold #(.HOLD_CYCLES(0), .CNT_W(8)) u_h0 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(dv_s),
        .din_ready(rdy0), .en(en), .dout(dout0), .busy(busy0),
        .done(done0), .last_code(lc0));

    typedef struct {
        logic [2:0] code;
        logic [7:0] word;
        int         width;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passed = 0;
    int   done_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: accumulate the visible word of the current hold, retire on done.
    logic [7:0] run_word = 8'h00;
    int         run_len = 0;
    logic       run_bad = 1'b0;

    always @(negedge clk) begin
        if (dout != 8'h00) begin
            if ($countones(dout) != 1) run_bad = 1'b1;
            if (run_word != 8'h00 && dout != run_word) run_bad = 1'b1;
            run_word = dout;
            run_len++;
        end
        if (done) begin
            done_count++;
            chk("done_dout_zero", {24'd0, dout}, 32'h0);
            chk("done_ready", {31'd0, din_ready}, 32'h1);
            if (sbq.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_word", {24'd0, run_word}, {24'd0, e.word});
                chk("sb_width", run_len, e.width);
                chk("sb_last_code", {29'd0, last_code}, {29'd0, e.code});
                chk("sb_onehot", {31'd0, run_bad}, 32'h0);
            end
            run_word = 8'h00;
            run_len  = 0;
            run_bad  = 1'b0;
        end else if (!busy) begin
            run_word = 8'h00;
            run_len  = 0;
            run_bad  = 1'b0;
        end
    end

    // Offer a code as soon as din_ready; width 0 means no done is expected.
    task automatic send(input logic [2:0] code, input logic [7:0] word, input int width);
        int n;
        n = 0;
        while (!din_ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) begin
            checks++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
        if (width > 0) sbq.push_back('{code, word, width});
        din       = code;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    logic [7:0] sweep_words [8];
    int         dc0;

    initial begin
        sweep_words = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        rst_n = 1'b0; din = 3'd0; din_valid = 1'b0; en = 1'b1; dv_s = 1'b0;
        tick(); tick();
        chk("rst_dout", {24'd0, dout}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_done", {31'd0, done}, 32'h0);
        chk("rst_ready", {31'd0, din_ready}, 32'h1);
        chk("rst_last_code", {29'd0, last_code}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Single code 5, four-cycle hold.
        send(3'd5, 8'h20, 4);
        chk("c5_cyc1_dout", {24'd0, dout}, 32'h20);
        chk("c5_cyc1_busy", {31'd0, busy}, 32'h1);
        chk("c5_cyc1_ready", {31'd0, din_ready}, 32'h0);
        tick(); tick(); tick();
        chk("c5_cyc4_dout", {24'd0, dout}, 32'h20);
        tick();
        chk("c5_cyc5_dout", {24'd0, dout}, 32'h0);
        chk("c5_cyc5_done", {31'd0, done}, 32'h1);
        chk("c5_cyc5_ready", {31'd0, din_ready}, 32'h1);
        chk("c5_last_code", {29'd0, last_code}, 32'h5);
        tick();
        chk("c5_done_single", {31'd0, done}, 32'h0);

        // Sweep all codes back to back.
        dc0 = done_count;
        for (int i = 0; i < 8; i++) send(3'(i), sweep_words[i], 4);
        repeat (6) tick();
        chk("sweep_done_count", done_count - dc0, 8);

        // Valid held high; code changes mid-hold and must wait for idle.
        sbq.push_back('{3'd6, 8'h40, 4});
        sbq.push_back('{3'd3, 8'h08, 4});
        din = 3'd6; din_valid = 1'b1;
        tick();
        din = 3'd3;
        chk("hv_cyc1_dout", {24'd0, dout}, 32'h40);
        tick(); tick(); tick();
        chk("hv_cyc4_dout", {24'd0, dout}, 32'h40);
        chk("hv_cyc4_last_code", {29'd0, last_code}, 32'h6);
        tick();
        chk("hv_cyc5_done", {31'd0, done}, 32'h1);
        chk("hv_cyc5_dout", {24'd0, dout}, 32'h0);
        tick();
        din_valid = 1'b0;
        chk("hv_next_dout", {24'd0, dout}, 32'h08);
        chk("hv_next_last_code", {29'd0, last_code}, 32'h3);
        repeat (5) tick();

        // Enable dropped for hold cycles 2-3.
        send(3'd2, 8'h04, 2);
        chk("en_cyc1_dout", {24'd0, dout}, 32'h04);
        tick();
        en = 1'b0; #1;
        chk("en_cyc2_dout", {24'd0, dout}, 32'h0);
        chk("en_cyc2_busy", {31'd0, busy}, 32'h1);
        tick();
        chk("en_cyc3_dout", {24'd0, dout}, 32'h0);
        tick();
        en = 1'b1; #1;
        chk("en_cyc4_dout", {24'd0, dout}, 32'h04);
        tick();
        chk("en_cyc5_done", {31'd0, done}, 32'h1);
        repeat (2) tick();

        // Reset in the middle of a hold: no done.
        send(3'd7, 8'h80, 0);
        chk("rh_cyc1_dout", {24'd0, dout}, 32'h80);
        tick();
        rst_n = 1'b0;
        tick();
        chk("rh_dout", {24'd0, dout}, 32'h0);
        chk("rh_busy", {31'd0, busy}, 32'h0);
        chk("rh_done", {31'd0, done}, 32'h0);
        chk("rh_last_code", {29'd0, last_code}, 32'h0);
        chk("rh_ready", {31'd0, din_ready}, 32'h1);

        // Transfer offered while reset is asserted is discarded.
        din = 3'd4; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        chk("rx_busy", {31'd0, busy}, 32'h0);
        chk("rx_last_code", {29'd0, last_code}, 32'h0);
        rst_n = 1'b1;
        repeat (6) tick();

        // Hold lengths of 1 and 0 both give a single-cycle word.
        din = 3'd3; dv_s = 1'b1;
        tick();
        dv_s = 1'b0;
        chk("h1_cyc1_dout", {24'd0, dout1}, 32'h08);
        chk("h0_cyc1_dout", {24'd0, dout0}, 32'h08);
        chk("h1_cyc1_done", {31'd0, done1}, 32'h0);
        tick();
        chk("h1_cyc2_dout", {24'd0, dout1}, 32'h0);
        chk("h1_cyc2_done", {31'd0, done1}, 32'h1);
        chk("h0_cyc2_dout", {24'd0, dout0}, 32'h0);
        chk("h0_cyc2_done", {31'd0, done0}, 32'h1);
        chk("h0_cyc2_ready", {31'd0, rdy0}, 32'h1);
        tick();
        chk("h0_cyc3_done", {31'd0, done0}, 32'h0);

        repeat (3) tick();
        chk("sb_empty", sbq.size(), 0);
        chk("total_done_count", done_count, 12);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
